// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer that owns the architectural HI/LO registers.
// Processes one operand bit per cycle, then applies sign correction in a single fixup cycle.
package muldiv_seq_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] muldiv_op_t;

  localparam muldiv_op_t OP_NONE = 3'd0;
  localparam muldiv_op_t OP_MUL  = 3'd1;
  localparam muldiv_op_t OP_DIV  = 3'd2;
  localparam muldiv_op_t OP_MTHI = 3'd3;
  localparam muldiv_op_t OP_MTLO = 3'd4;
  localparam muldiv_op_t OP_MFHI = 3'd5;
  localparam muldiv_op_t OP_MFLO = 3'd6;
endpackage

module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            op_valid,
  input  muldiv_op_t      op,
  input  logic            op_u,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned      CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   sreg_q, sreg_d;  // multiplier, or dividend shifting into quotient
  logic [XLEN-1:0]   opb_q, opb_d;    // multiplicand, or divisor
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              quot_neg_q, quot_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              is_div_q, is_div_d;
  logic              div0_q, div0_d;

  logic            is_md_op;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;

  assign is_md_op = (op == OP_MUL)  || (op == OP_DIV)  || (op == OP_MTHI) ||
                    (op == OP_MTLO) || (op == OP_MFHI) || (op == OP_MFLO);
  assign stall = op_valid & busy_q & is_md_op;
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  assign mag_a = (~op_u & a[XLEN-1]) ? -a : a;
  assign mag_b = (~op_u & b[XLEN-1]) ? -b : b;

  // Shift-add step: the carry out of the upper-half add becomes the new MSB.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (sreg_q[0] ? {1'b0, opb_q} : '0);

  // Restoring step: shift in the next dividend bit, then trial-subtract.
  assign div_shift = {rem_q, sreg_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      sreg_q     <= '0;
      opb_q      <= '0;
      rem_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_q      <= acc_d;
      sreg_q     <= sreg_d;
      opb_q      <= opb_d;
      rem_q      <= rem_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      is_div_q   <= is_div_d;
      div0_q     <= div0_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    sreg_d     = sreg_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    is_div_d   = is_div_q;
    div0_d     = div0_q;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MUL, OP_DIV: begin
              state_d    = (op == OP_MUL) ? S_MUL : S_DIV;
              busy_d     = 1'b1;
              cnt_d      = '0;
              acc_d      = '0;
              rem_d      = '0;
              sreg_d     = mag_a;
              opb_d      = mag_b;
              quot_neg_d = (a[XLEN-1] ^ b[XLEN-1]) & ~op_u;
              rem_neg_d  = a[XLEN-1] & ~op_u;
              is_div_d   = (op == OP_DIV);
              div0_d     = (b == '0);
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        acc_d  = {mul_sum, acc_q[XLEN-1:1]};
        sreg_d = sreg_q >> 1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end

      S_DIV: begin
        rem_d  = div_ge ? XLEN'(div_shift - {1'b0, opb_q}) : div_shift[XLEN-1:0];
        sreg_d = {sreg_q[XLEN-2:0], div_ge};
        if (cnt_q == CNT_LAST) state_d = S_FIX;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end

      S_FIX: begin
        if (is_div_q) begin
          lo_d = div0_q ? DIV0_QUOT : (quot_neg_q ? -sreg_q : sreg_q);
          hi_d = rem_neg_q ? -rem_q : rem_q;
        end else begin
          {hi_d, lo_d} = quot_neg_q ? -acc_q : acc_q;
        end
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
